// File: rtl/range_scan_ctrl_pkg.sv
// Shared definitions for the range scan controller: default sizes, FSM states
// and the BCD digit legality helper.
package range_scan_ctrl_pkg;

    localparam int unsigned DEF_DIGITS = 11;
    localparam int unsigned DEF_BIN_W  = 37;   // 2^37 > 10^11
    localparam int unsigned DEF_SUM_W  = 64;
    localparam int unsigned DEF_CNT_W  = 32;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StScan,
        StFin
    } state_e;

    // True when a nibble is a legal decimal digit.
    function automatic logic nibble_ok(input logic [3:0] nib);
        return nib <= 4'd9;
    endfunction

endpackage

// File: rtl/range_scan_ctrl_bcd_inc.sv
// Combinational DIGITS-digit BCD increment. A 9 wraps to 0 and carries into
// the next digit; the carry out of the top digit is dropped.
module range_scan_ctrl_bcd_inc
    import range_scan_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS = DEF_DIGITS
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    output logic [4*DIGITS-1:0] bcd_o
);

    logic       carry;
    logic [3:0] nib;

    // Ripple the +1 from the least significant digit upwards.
    always_comb begin
        bcd_o = '0;
        carry = 1'b1;
        nib   = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            nib = bcd_i[4*i +: 4];
            if (carry && (nib == 4'd9)) begin
                bcd_o[4*i +: 4] = 4'd0;
            end else begin
                bcd_o[4*i +: 4] = nib + {3'b000, carry};
                carry           = 1'b0;
            end
        end
    end

endmodule

// File: rtl/range_scan_ctrl.sv
// Walks every ID of an inclusive BCD range, one candidate per cycle, feeding an
// external repeated-half comparator and accumulating the binary value of every
// matching candidate.
module range_scan_ctrl
    import range_scan_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS = DEF_DIGITS,
    parameter int unsigned SUM_W  = DEF_SUM_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned BIN_W  = DEF_BIN_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_lo,
    input  logic [4*DIGITS-1:0] in_hi,
    output logic [4*DIGITS-1:0] cand_bcd,
    input  logic                cand_eq,
    input  logic                sum_clr,
    output logic                busy,
    output logic                range_done,
    output logic                bcd_err,
    output logic [CNT_W-1:0]    match_cnt,
    output logic [SUM_W-1:0]    sum_o
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     cur_bcd_q, cur_bcd_d;
    logic [W-1:0]     hi_bcd_q, hi_bcd_d;
    logic [W-1:0]     cand_q, cand_d;
    logic [W-1:0]     cur_bcd_inc;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             err_q, err_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;
    logic [3:0]       lo_nib, hi_nib;

    // During CONV both bounds are rotated left one digit per cycle so the digit
    // being converted is always the top nibble; DIGITS rotations restore them.
    function automatic logic [W-1:0] rotl_digit(input logic [W-1:0] v);
        return (v << 4) | (v >> (W - 4));
    endfunction

    assign lo_nib = cur_bcd_q[W-1 -: 4];
    assign hi_nib = hi_bcd_q[W-1 -: 4];

    range_scan_ctrl_bcd_inc #(
        .DIGITS (DIGITS)
    ) u_bcd_inc (
        .bcd_i (cur_bcd_q),
        .bcd_o (cur_bcd_inc)
    );

    // Next-state logic for the range walk.
    always_comb begin
        state_d   = state_q;
        cur_bcd_d = cur_bcd_q;
        hi_bcd_d  = hi_bcd_q;
        cand_d    = cand_q;
        bin_d     = bin_q;
        idx_d     = idx_q;
        err_d     = err_q;
        hit       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    cur_bcd_d = in_lo;
                    hi_bcd_d  = in_hi;
                    bin_d     = '0;
                    idx_d     = '0;
                    err_d     = 1'b0;
                    state_d   = StConv;
                end
            end
            StConv: begin
                cur_bcd_d = rotl_digit(cur_bcd_q);
                hi_bcd_d  = rotl_digit(hi_bcd_q);
                bin_d     = (bin_q << 3) + (bin_q << 1) + BIN_W'(lo_nib);
                idx_d     = idx_q + 1'b1;
                if (!nibble_ok(lo_nib) || !nibble_ok(hi_nib)) begin
                    err_d = 1'b1;
                end
                if (idx_q == LastIdx) begin
                    idx_d = '0;
                    // Raw unsigned compare of the restored bounds; exact for legal BCD.
                    if (err_d || (cur_bcd_d > hi_bcd_d)) begin
                        state_d = StFin;
                    end else begin
                        state_d = StScan;
                    end
                end
            end
            StScan: begin
                cand_d = cur_bcd_q;
                hit    = cand_eq;
                if (cur_bcd_q == hi_bcd_q) begin
                    state_d = StFin;
                end else begin
                    cur_bcd_d = cur_bcd_inc;
                    bin_d     = bin_q + 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Match accumulation: a clear takes effect first, then this cycle's match adds.
    always_comb begin
        sum_d = sum_clr ? '0 : sum_q;
        cnt_d = sum_clr ? '0 : cnt_q;
        if (hit) begin
            sum_d = sum_d + SUM_W'(bin_q);
            cnt_d = cnt_d + 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cur_bcd_q <= '0;
            hi_bcd_q  <= '0;
            cand_q    <= '0;
            bin_q     <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            sum_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_bcd_q <= cur_bcd_d;
            hi_bcd_q  <= hi_bcd_d;
            cand_q    <= cand_d;
            bin_q     <= bin_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
        end
    end

    // The comparator sees the live candidate in SCAN and the last one otherwise.
    assign cand_bcd   = (state_q == StScan) ? cur_bcd_q : cand_q;
    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q == StConv) || (state_q == StScan);
    assign range_done = (state_q == StFin);
    assign bcd_err    = (state_q == StFin) && err_q;
    assign match_cnt  = cnt_q;
    assign sum_o      = sum_q;

endmodule

// File: tb/tb_range_scan_ctrl.sv
// Bench for range_scan_ctrl: directed ranges with hand-computed results, then
// random ranges checked every cycle against a timeline model of the scan.
module tb_range_scan_ctrl;

    localparam int DIGITS = 11;
    localparam int W      = 4 * DIGITS;
    localparam int Bound  = 2000;
    localparam longint unsigned MaxId = 64'd99999999999;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_lo = '0;
    logic [W-1:0] in_hi = '0;
    logic [W-1:0] cand_bcd;
    logic         cand_eq;
    logic         sum_clr = 1'b0;
    logic         busy;
    logic         range_done;
    logic         bcd_err;
    logic [31:0]  match_cnt;
    logic [63:0]  sum_o;

    int           tests = 0;
    int           fails = 0;
    bit           chk_en = 1'b0;
    bit           rand_en = 1'b0;
    bit           clr_en = 1'b0;
    bit           noise = 1'b0;
    logic [W-1:0] clr_at = '0;

    always #5 clk = ~clk;

    range_scan_ctrl #(
        .DIGITS (DIGITS),
        .SUM_W  (64),
        .CNT_W  (32),
        .BIN_W  (37)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_lo      (in_lo),
        .in_hi      (in_hi),
        .cand_bcd   (cand_bcd),
        .cand_eq    (cand_eq),
        .sum_clr    (sum_clr),
        .busy       (busy),
        .range_done (range_done),
        .bcd_err    (bcd_err),
        .match_cnt  (match_cnt),
        .sum_o      (sum_o)
    );

    function automatic logic [W-1:0] to_bcd(input longint unsigned v);
        logic [W-1:0] b = '0;
        longint unsigned x = v;
        for (int i = 0; i < DIGITS; i++) begin
            b = b | (W'(x % 10) << (4 * i));
            x = x / 10;
        end
        return b;
    endfunction

    function automatic longint unsigned from_bcd(input logic [W-1:0] b);
        longint unsigned v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + 64'(4'(b >> (4 * i)));
        return v;
    endfunction

    function automatic bit bcd_legal(input logic [W-1:0] b);
        for (int i = 0; i < DIGITS; i++) if (4'(b >> (4 * i)) > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Repeated-half rule: even number of decimal digits, first half == second half.
    function automatic bit is_rep(input longint unsigned v);
        longint unsigned p = 1;
        longint unsigned h = 1;
        int len = 0;
        if (v == 0) return 1'b0;
        while (p <= v) begin
            p = p * 10;
            len++;
        end
        if (len % 2 != 0) return 1'b0;
        repeat (len / 2) h = h * 10;
        return (v / h) == (v % h);
    endfunction

    // External comparator, with optional injected extra matches.
    assign cand_eq = is_rep(from_bcd(cand_bcd)) | noise;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL timeout %s: got no event within %0d cycles, expected one", name, Bound);
    endtask

    // ---------------- behavioural model ----------------
    // A range is a timeline counted from the accept edge: cycles 1..DIGITS convert,
    // the next n cycles present lo..hi, then one cycle reports completion.
    bit               m_act;
    int               m_t;
    int               m_n;
    bit               m_err;
    longint unsigned  m_lo;
    logic [63:0]      m_sum;
    logic [31:0]      m_cnt;
    logic [W-1:0]     m_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act  <= 1'b0;
            m_t    <= 0;
            m_n    <= 0;
            m_err  <= 1'b0;
            m_lo   <= 0;
            m_sum  <= '0;
            m_cnt  <= '0;
            m_hold <= '0;
        end else begin
            logic [63:0] s;
            logic [31:0] c;
            longint unsigned v, lo, hi;
            bit ok;
            s = sum_clr ? 64'd0 : m_sum;
            c = sum_clr ? 32'd0 : m_cnt;
            if (m_act && m_t > DIGITS && m_t <= DIGITS + m_n) begin
                v = m_lo + longint'(m_t - DIGITS - 1);
                if (is_rep(v) || noise) begin
                    s = s + v;
                    c = c + 1;
                end
                m_hold <= to_bcd(v);
            end
            m_sum <= s;
            m_cnt <= c;
            if (m_act) begin
                if (m_t == DIGITS + m_n + 1) m_act <= 1'b0;
                else m_t <= m_t + 1;
            end else if (in_valid) begin
                ok = bcd_legal(in_lo) && bcd_legal(in_hi);
                lo = from_bcd(in_lo);
                hi = from_bcd(in_hi);
                m_err <= !ok;
                m_lo  <= lo;
                m_n   <= (!ok || lo > hi) ? 0 : int'(hi - lo + 1);
                m_act <= 1'b1;
                m_t   <= 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit scan, fin;
            logic [W-1:0] ecand;
            scan  = m_act && m_t > DIGITS && m_t <= DIGITS + m_n;
            fin   = m_act && m_t == DIGITS + m_n + 1;
            ecand = scan ? to_bcd(m_lo + longint'(m_t - DIGITS - 1)) : m_hold;
            check("in_ready", 64'(in_ready), 64'(!m_act));
            check("busy", 64'(busy), 64'(m_act && !fin));
            check("range_done", 64'(range_done), 64'(fin));
            check("bcd_err", 64'(bcd_err), 64'(fin && m_err));
            check("cand_bcd", 64'(cand_bcd), 64'(ecand));
            check("match_cnt", 64'(match_cnt), 64'(m_cnt));
            check("sum_o", sum_o, m_sum);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        noise = rand_en ? ($urandom_range(7, 0) == 0) : 1'b0;
        if (rand_en) sum_clr = ($urandom_range(15, 0) == 0);
        else sum_clr = clr_en && (cand_bcd == clr_at);
    endtask

    task automatic clear();
        sum_clr = 1'b1;
        @(posedge clk);
        #1;
        sum_clr = 1'b0;
    endtask

    // lat numbers cycles with the accept cycle as 1; returns with the FIN cycle done.
    task automatic wait_done(inout int lat, output bit err_seen);
        err_seen = 1'b0;
        while (!range_done && lat < Bound) begin
            tick();
            lat++;
        end
        if (!range_done) begin
            timeout("range_done");
            return;
        end
        err_seen = bcd_err;
        tick();
    endtask

    task automatic run_range(input logic [W-1:0] lo, input logic [W-1:0] hi,
                             output int lat, output bit err_seen);
        int k = 0;
        lat      = 0;
        err_seen = 1'b0;
        in_lo    = lo;
        in_hi    = hi;
        in_valid = 1'b1;
        while (!in_ready && k < Bound) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            timeout("accept");
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        lat = 2;
        wait_done(lat, err_seen);
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_range_done"}, 64'(range_done), 64'd0);
        check({tag, "_bcd_err"}, 64'(bcd_err), 64'd0);
        check({tag, "_cand_bcd"}, 64'(cand_bcd), 64'd0);
        check({tag, "_match_cnt"}, 64'(match_cnt), 64'd0);
        check({tag, "_sum_o"}, sum_o, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by %0t, expected one", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, k;
        bit err;
        longint unsigned lo_v, hi_v, m, t;
        logic [W-1:0] lo_b, hi_b;

        #2 rst_n = 1'b0;
        #1 reset_values("rst");
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // 11..22: matches 11 and 22; done in cycle 2+11+12 counting the accept cycle.
        clear();
        run_range(to_bcd(11), to_bcd(22), lat, err);
        check("r11_22_lat", 64'(lat), 64'd25);
        check("r11_22_err", 64'(err), 64'd0);
        check("r11_22_cnt", 64'(match_cnt), 64'd2);
        check("r11_22_sum", sum_o, 64'd33);

        // Back-to-back with in_valid held: 95..115 then 998..1012 -> 99 + 1010.
        clear();
        in_lo = to_bcd(95);
        in_hi = to_bcd(115);
        in_valid = 1'b1;
        tick();
        in_lo = to_bcd(998);
        in_hi = to_bcd(1012);
        lat = 2;
        wait_done(lat, err);
        check("b2b_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        lat = 2;
        wait_done(lat, err);
        check("b2b_lat2", 64'(lat), 64'd28);
        check("b2b_cnt", 64'(match_cnt), 64'd2);
        check("b2b_sum", sum_o, 64'd1109);

        // Empty range: lo > hi is not an error and produces no candidates.
        run_range(to_bcd(30), to_bcd(20), lat, err);
        check("empty_lat", 64'(lat), 64'd13);
        check("empty_err", 64'(err), 64'd0);
        check("empty_sum", sum_o, 64'd1109);

        // Illegal nibble in lo.
        run_range(44'h1A, 44'h50, lat, err);
        check("badbcd_lat", 64'(lat), 64'd13);
        check("badbcd_err", 64'(err), 64'd1);
        check("badbcd_cnt", 64'(match_cnt), 64'd2);
        check("badbcd_sum", sum_o, 64'd1109);

        // Clear coinciding with the match at 1188511885: clear-then-add.
        clr_en = 1'b1;
        clr_at = to_bcd(64'd1188511885);
        run_range(to_bcd(64'd1188511880), to_bcd(64'd1188511890), lat, err);
        clr_en = 1'b0;
        check("clr_add_lat", 64'(lat), 64'd24);
        check("clr_add_cnt", 64'(match_cnt), 64'd1);
        check("clr_add_sum", sum_o, 64'd1188511885);

        // Asynchronous reset in the middle of a scan.
        in_lo = to_bcd(11);
        in_hi = to_bcd(99);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (cand_bcd != to_bcd(40) && k < Bound) begin
            tick();
            k++;
        end
        if (k == Bound) timeout("mid_scan");
        check("mid_scan_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 reset_values("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);
        run_range(to_bcd(11), to_bcd(11), lat, err);
        check("post_rst_lat", 64'(lat), 64'd14);
        check("post_rst_cnt", 64'(match_cnt), 64'd1);
        check("post_rst_sum", sum_o, 64'd11);

        // Random ranges with injected matches and random clears.
        rand_en = 1'b1;
        for (int r = 0; r < 60; r++) begin
            m = 1;
            repeat ($urandom_range(DIGITS, 1)) m = m * 10;
            lo_v = {$urandom, $urandom} % m;
            hi_v = lo_v + $urandom_range(30, 0);
            if (hi_v > MaxId) hi_v = MaxId;
            case ($urandom_range(9, 0))
                0: begin
                    t = lo_v;
                    lo_v = hi_v;
                    hi_v = t;
                end
                default: ;
            endcase
            lo_b = to_bcd(lo_v);
            hi_b = to_bcd(hi_v);
            case ($urandom_range(9, 0))
                0: lo_b = lo_b | (W'(4'hA) << (4 * $urandom_range(DIGITS - 1, 0)));
                1: hi_b = hi_b | (W'(4'hA) << (4 * $urandom_range(DIGITS - 1, 0)));
                default: ;
            endcase
            run_range(lo_b, hi_b, lat, err);
            repeat ($urandom_range(3, 0)) tick();
        end
        rand_en = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
